clkdiv_ctrl: RTL
================

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 Parameters SHALL be: MAX_RATIO, default 32, largest legal divide ratio; RATIO_BIT, default $clog2(MAX_RATIO)+1, ratio bus width; DEFAULT_RATIO, default 1, ratio driven out of reset; SETTLE_CYCLES, default 2, idle cycles between divider disable and ratio load.
REQ-002 i_ref_clk  input  1  sole clock, rising-edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_cfg_valid  input  1  new-ratio request.
REQ-005 i_cfg_ratio  input  RATIO_BIT  requested ratio; sampled on handshake.
REQ-006 o_cfg_ready  output  1  controller accepts a request this cycle.
REQ-007 i_stop  input  1  request to disable the divider.
REQ-008 i_div_clk  input  1  feedback from the divider output (o_div_clk).
REQ-009 o_clk_en  output  1  drives the divider's i_clk_en.
REQ-010 o_div_ratio  output  RATIO_BIT  drives the divider's i_div_ratio.
REQ-011 o_locked  output  1  divider running at the committed ratio.
REQ-012 o_err  output  1  one-cycle pulse on a rejected request or lock timeout.

Function
REQ-013 States SHALL be IDLE, DRAIN, SETTLE, LOAD, LOCK and RUN; all outputs SHALL be registered except o_cfg_ready.
REQ-014 o_cfg_ready SHALL equal (state==IDLE or state==RUN) and !i_stop.
REQ-015 A transfer SHALL occur on a cycle with i_cfg_valid and o_cfg_ready both high; i_cfg_ratio SHALL be captured into a shadow register on that edge.
REQ-016 A transfer with i_cfg_ratio > MAX_RATIO SHALL be rejected: o_err pulses high the next cycle, and state, shadow, o_clk_en and o_div_ratio remain unchanged.
REQ-017 A legal transfer in IDLE SHALL go to SETTLE; a legal transfer in RUN SHALL clear o_locked and go to DRAIN.
REQ-018 In DRAIN, o_clk_en SHALL stay 1 until i_div_clk is sampled 0; o_clk_en SHALL then clear on that same edge and the state SHALL move to SETTLE, so that the divider is never disabled mid-high-phase.
REQ-019 SETTLE SHALL hold o_clk_en=0 for exactly SETTLE_CYCLES cycles, then move to LOAD.
REQ-020 LOAD SHALL last one cycle with o_div_ratio <= shadow; the next state SHALL be LOCK with o_clk_en <= 1.
REQ-021 In LOCK with shadow >= 2, the block SHALL count rising edges of sampled i_div_clk; on the second edge it SHALL go to RUN and set o_locked=1.
REQ-022 In LOCK with shadow of 0 or 1 (divider bypass), the block SHALL go to RUN after exactly one cycle and set o_locked=1, with no edge detection.
REQ-023 When i_stop is high in RUN, LOCK or DRAIN, o_locked SHALL clear and the state SHALL move to DRAIN with the target set to IDLE; after SETTLE it SHALL go to IDLE, skipping LOAD, with o_div_ratio retained.
REQ-024 i_stop in IDLE or SETTLE SHALL have no effect other than blocking o_cfg_ready.
REQ-025 When i_stop and i_cfg_valid are high in the same cycle, stop SHALL win and no transfer SHALL occur.
REQ-026 i_cfg_valid outside IDLE and RUN SHALL be ignored; the requester holds it until ready.

Reset
REQ-027 Reset assertion SHALL asynchronously set state=IDLE, o_clk_en=0, o_div_ratio=DEFAULT_RATIO, shadow=DEFAULT_RATIO, o_locked=0, o_err=0, and clear all counters, including when asserted mid-sequence.
REQ-028 After reset deassertion, o_cfg_ready SHALL be 1 in the first cycle unless i_stop is high.

Configuration
REQ-029 With macro CLKDIV_CTRL_TIMEOUT_EN defined, a watchdog SHALL count cycles in LOCK; if 4*MAX_RATIO+8 cycles elapse without lock, it SHALL pulse o_err, clear o_clk_en and go to IDLE.
REQ-030 With CLKDIV_CTRL_TIMEOUT_EN undefined, no watchdog SHALL exist, LOCK SHALL wait indefinitely, and o_err SHALL come only from REQ-016.

Verification
REQ-031 Reset, then request ratio 4 from IDLE -> 2 SETTLE cycles, then o_div_ratio=4 and o_clk_en=1; o_locked=1 after the 2nd divided-clock rise; divided period 40ns at a 10ns ref clock.
REQ-032 In RUN at ratio 4, request ratio 7 -> o_clk_en falls only while the divided clock is low, o_div_ratio=7 after SETTLE, then lock with a 70ns period.
REQ-033 Request ratio 40 with MAX_RATIO=32 -> o_err is a 1-cycle pulse and o_div_ratio, o_clk_en and o_locked are unchanged.
REQ-034 Request ratios 0 and 1 -> o_locked=1 exactly 1 cycle after LOAD; i_stop and i_cfg_valid in the same cycle in RUN -> no transfer, goes to IDLE, o_clk_en=0.
REQ-035 Reset asserted in SETTLE -> outputs immediately at their reset values; with CLKDIV_CTRL_TIMEOUT_EN defined and i_div_clk tied low -> o_err after 136 LOCK cycles (MAX_RATIO=32), then IDLE.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// Ratio controller for an external clock divider: drains on a low phase, settles, loads, locks.
// Define CLKDIV_CTRL_TIMEOUT_EN to add a LOCK watchdog that aborts to IDLE with an o_err pulse.
module clkdiv_ctrl #(
    parameter int MAX_RATIO     = 32,
    parameter int RATIO_BIT     = $clog2(MAX_RATIO) + 1,
    parameter int DEFAULT_RATIO = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cfg_valid,
    input  logic [RATIO_BIT-1:0] i_cfg_ratio,
    output logic                 o_cfg_ready,
    input  logic                 i_stop,
    input  logic                 i_div_clk,
    output logic                 o_clk_en,
    output logic [RATIO_BIT-1:0] o_div_ratio,
    output logic                 o_locked,
    output logic                 o_err,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SETTLE = 3'd2,
        LOAD   = 3'd3,
        LOCK   = 3'd4,
        RUN    = 3'd5
    } state_t;

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]      SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [RATIO_BIT-1:0] MAX_R       = RATIO_BIT'(MAX_RATIO);
    localparam logic [RATIO_BIT-1:0] DEF_R       = RATIO_BIT'(DEFAULT_RATIO);
    localparam logic [RATIO_BIT-1:0] BYPASS_LIM  = RATIO_BIT'(2);

`ifdef CLKDIV_CTRL_TIMEOUT_EN
    localparam int WD_LIMIT = 4 * MAX_RATIO + 8;
    localparam int WD_W     = $clog2(WD_LIMIT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
    logic [WD_W-1:0] wd_cnt, wd_n;
`endif

    state_t               state, state_n;
    logic [RATIO_BIT-1:0] shadow, shadow_n, ratio_n;
    logic [SC_W-1:0]      settle_cnt, settle_n;
    logic                 clk_en_n, locked_n, err_n;
    logic                 edge_seen, edge_n;
    logic                 to_idle, to_idle_n;
    logic                 div_q;
    logic                 xfer, legal, rise;

    // Handshake: a request transfers on any rising edge where i_cfg_valid and
    // o_cfg_ready are both high; i_cfg_ratio is captured on that edge. The
    // requester keeps i_cfg_valid/i_cfg_ratio stable until it sees ready.
    assign o_cfg_ready = ((state == IDLE) || (state == RUN)) && !i_stop;
    assign xfer        = i_cfg_valid && o_cfg_ready;
    assign legal       = (i_cfg_ratio <= MAX_R);
    assign rise        = i_div_clk && !div_q;
    assign o_state     = state;

    always_comb begin
        state_n   = state;
        shadow_n  = shadow;
        ratio_n   = o_div_ratio;
        clk_en_n  = o_clk_en;
        locked_n  = o_locked;
        err_n     = 1'b0;
        settle_n  = settle_cnt;
        edge_n    = edge_seen;
        to_idle_n = to_idle;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
        wd_n      = wd_cnt;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (legal) begin
                        shadow_n  = i_cfg_ratio;
                        to_idle_n = 1'b0;
                        settle_n  = '0;
                        state_n   = SETTLE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (i_stop) begin
                    locked_n  = 1'b0;
                    to_idle_n = 1'b1;
                    state_n   = DRAIN;
                end else if (xfer) begin
                    if (legal) begin
                        shadow_n  = i_cfg_ratio;
                        locked_n  = 1'b0;
                        to_idle_n = 1'b0;
                        state_n   = DRAIN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Only gate the divider while its output is low, so no runt high pulse escapes.
                locked_n = 1'b0;
                if (i_stop) to_idle_n = 1'b1;
                if (!i_div_clk) begin
                    clk_en_n = 1'b0;
                    settle_n = '0;
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    if (to_idle) begin
                        state_n = IDLE;
                    end else begin
                        ratio_n = shadow;
                        state_n = LOAD;
                    end
                end else begin
                    settle_n = settle_cnt + 1'b1;
                end
            end
            LOAD: begin
                clk_en_n = 1'b1;
                edge_n   = 1'b0;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
                wd_n     = '0;
`endif
                state_n  = LOCK;
            end
            LOCK: begin
                if (rise) edge_n = 1'b1;
                if (i_stop) begin
                    locked_n  = 1'b0;
                    to_idle_n = 1'b1;
                    state_n   = DRAIN;
                end else if ((shadow < BYPASS_LIM) || (rise && edge_seen)) begin
                    locked_n = 1'b1;
                    state_n  = RUN;
                end
`ifdef CLKDIV_CTRL_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    err_n    = 1'b1;
                    clk_en_n = 1'b0;
                    state_n  = IDLE;
                end else begin
                    wd_n = wd_cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            shadow      <= DEF_R;
            o_div_ratio <= DEF_R;
            o_clk_en    <= 1'b0;
            o_locked    <= 1'b0;
            o_err       <= 1'b0;
            settle_cnt  <= '0;
            edge_seen   <= 1'b0;
            to_idle     <= 1'b0;
            div_q       <= 1'b0;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            state       <= state_n;
            shadow      <= shadow_n;
            o_div_ratio <= ratio_n;
            o_clk_en    <= clk_en_n;
            o_locked    <= locked_n;
            o_err       <= err_n;
            settle_cnt  <= settle_n;
            edge_seen   <= edge_n;
            to_idle     <= to_idle_n;
            div_q       <= i_div_clk;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
            wd_cnt      <= wd_n;
`endif
        end
    end

endmodule
